// File: rtl/acq_seq_ctrl.sv
// ----------------------------------------------------------------------------
// acq_seq_ctrl
// Acquisition sequencer for the ADC receive datapath (rx_clk1 domain).
// Latches the capture configuration on arm, holds the active-low count clear
// into the normal/peak paths for CLR_CYCLES cycles, then gates the datapath
// write strobe through the pre-trigger, wait-trigger and post-trigger phases.
//
// Ports:
//   rx_clk1, rx_reset          clock, asynchronous active-high reset
//   arm, abort                 single-cycle start / cancel requests
//   cfg_*                      capture configuration, sampled at arm
//   trig_in, force_trig        trigger level (rising edge used), forced trigger
//   fifo_all_wen, fifo_full    datapath word valid, downstream FIFO full
//   count_clr                  active-low clear to the datapath (registered)
//   peak_mode .. div_n_maxmin  latched configuration
//   wr_gate                    qualified FIFO write enable (combinational)
//   words_written, trig_pos    accepted words since arm, count at trigger
//   acq_busy, acq_done         status flags
//   overflow                   sticky: a word was offered while FIFO full
//   state                      IDLE=0 CLEAR=1 PRE=2 WAIT_TRIG=3 POST=4 DONE=5
// ----------------------------------------------------------------------------
module acq_seq_ctrl #(
    parameter int CNT_W      = 32,
    parameter int CLR_CYCLES = 4
) (
    input  logic             rx_clk1,
    input  logic             rx_reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             cfg_peak_mode,
    input  logic             cfg_extract_enable,
    input  logic [31:0]      cfg_div_n,
    input  logic [31:0]      cfg_div_n_maxmin,
    input  logic [CNT_W-1:0] cfg_pre_len,
    input  logic [CNT_W-1:0] cfg_post_len,
    input  logic             trig_in,
    input  logic             force_trig,
    input  logic             fifo_all_wen,
    input  logic             fifo_full,
    output logic             count_clr,
    output logic             peak_mode,
    output logic             extract_enable,
    output logic [31:0]      div_n,
    output logic [31:0]      div_n_maxmin,
    output logic             wr_gate,
    output logic [CNT_W-1:0] words_written,
    output logic [CNT_W-1:0] trig_pos,
    output logic             acq_busy,
    output logic             acq_done,
    output logic             overflow,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = {{(CLR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] pre_len_r;
    logic [CNT_W-1:0] post_len_r;
    logic [CNT_W-1:0] phase_cnt_r;
    logic [CLR_W-1:0] clr_cnt_r;
    logic             trig_in_d_r;

    logic             active_s;
    logic             accept_s;
    logic             trigger_s;
    logic             arm_take_s;
    logic [CNT_W-1:0] phase_nxt_s;
    logic [CNT_W-1:0] words_nxt_s;
    logic [2:0]       next_state_s;

    // Phase qualification, write gating and trigger detection.
    always_comb begin
        active_s    = 1'b0;
        wr_gate     = 1'b0;
        accept_s    = 1'b0;
        trigger_s   = 1'b0;
        arm_take_s  = 1'b0;
        phase_nxt_s = phase_cnt_r;
        words_nxt_s = words_written;

        if ((state == S_PRE) || (state == S_WAIT) || (state == S_POST)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end

        // A zero-length post phase must not take any words before DONE.
        if ((state == S_POST) && (post_len_r == CNT_ZERO)) begin
            wr_gate = 1'b0;
        end else begin
            wr_gate = fifo_all_wen & ~fifo_full & active_s;
        end
        accept_s = wr_gate;

        if (accept_s) begin
            phase_nxt_s = phase_cnt_r + CNT_ONE;
            words_nxt_s = words_written + CNT_ONE;
        end else begin
            phase_nxt_s = phase_cnt_r;
            words_nxt_s = words_written;
        end

        // trig_in_d_r tracks trig_in in every state, so a level already high on
        // entry to WAIT_TRIG has to fall and rise again before it counts.
        if (state == S_WAIT) begin
            trigger_s = (trig_in & ~trig_in_d_r) | force_trig;
        end else begin
            trigger_s = 1'b0;
        end

        if (((state == S_IDLE) || (state == S_DONE)) && arm && !abort) begin
            arm_take_s = 1'b1;
        end else begin
            arm_take_s = 1'b0;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        next_state_s = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) next_state_s = S_CLEAR;
                else     next_state_s = state;
            end
            S_CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    if (pre_len_r == CNT_ZERO) next_state_s = S_WAIT;
                    else                       next_state_s = S_PRE;
                end else begin
                    next_state_s = S_CLEAR;
                end
            end
            S_PRE: begin
                if (phase_nxt_s == pre_len_r) next_state_s = S_WAIT;
                else                          next_state_s = S_PRE;
            end
            S_WAIT: begin
                if (trigger_s) next_state_s = S_POST;
                else           next_state_s = S_WAIT;
            end
            S_POST: begin
                if ((post_len_r == CNT_ZERO) || (phase_nxt_s == post_len_r)) next_state_s = S_DONE;
                else                                                         next_state_s = S_POST;
            end
            default: next_state_s = S_IDLE;
        endcase

        if (abort) begin
            next_state_s = S_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register and status flags decoded from the next state.
    always_ff @(posedge rx_clk1 or posedge rx_reset) begin
        if (rx_reset) begin
            state       <= S_IDLE;
            count_clr   <= 1'b1;
            acq_busy    <= 1'b0;
            acq_done    <= 1'b0;
            trig_in_d_r <= 1'b0;
            clr_cnt_r   <= {CLR_W{1'b0}};
        end else begin
            state       <= next_state_s;
            count_clr   <= (next_state_s != S_CLEAR);
            acq_busy    <= (next_state_s == S_CLEAR) || (next_state_s == S_PRE) ||
                           (next_state_s == S_WAIT)  || (next_state_s == S_POST);
            acq_done    <= (next_state_s == S_DONE);
            trig_in_d_r <= trig_in;
            if (state == S_CLEAR) clr_cnt_r <= clr_cnt_r + CLR_ONE;
            else                  clr_cnt_r <= {CLR_W{1'b0}};
        end
    end

    // Configuration latch, word/phase counters, trigger position and overflow.
    always_ff @(posedge rx_clk1 or posedge rx_reset) begin
        if (rx_reset) begin
            peak_mode      <= 1'b0;
            extract_enable <= 1'b0;
            div_n          <= 32'd0;
            div_n_maxmin   <= 32'd0;
            pre_len_r      <= CNT_ZERO;
            post_len_r     <= CNT_ZERO;
            words_written  <= CNT_ZERO;
            trig_pos       <= CNT_ZERO;
            phase_cnt_r    <= CNT_ZERO;
            overflow       <= 1'b0;
        end else if (arm_take_s) begin
            peak_mode      <= cfg_peak_mode;
            extract_enable <= cfg_extract_enable;
            div_n          <= cfg_div_n;
            div_n_maxmin   <= cfg_div_n_maxmin;
            pre_len_r      <= cfg_pre_len;
            post_len_r     <= cfg_post_len;
            words_written  <= CNT_ZERO;
            trig_pos       <= CNT_ZERO;
            phase_cnt_r    <= CNT_ZERO;
            overflow       <= 1'b0;
        end else begin
            words_written <= words_nxt_s;
            // Trigger position includes a word accepted in the trigger cycle.
            if (trigger_s && !abort) begin
                trig_pos    <= words_nxt_s;
                phase_cnt_r <= CNT_ZERO;
            end else begin
                trig_pos    <= trig_pos;
                phase_cnt_r <= phase_nxt_s;
            end
            if (active_s && fifo_all_wen && fifo_full) overflow <= 1'b1;
            else                                      overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acq_seq_ctrl
// Directed self-checking bench for acq_seq_ctrl (CNT_W=32, CLR_CYCLES=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_acq_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, abort, cfg_peak_mode, cfg_extract_enable;
    logic [31:0] cfg_div_n, cfg_div_n_maxmin, cfg_pre_len, cfg_post_len;
    logic        trig_in, force_trig, fifo_all_wen, fifo_full;
    logic        count_clr, peak_mode, extract_enable, wr_gate;
    logic [31:0] div_n, div_n_maxmin, ww, trig_pos;
    logic        acq_busy, acq_done, overflow;
    logic [2:0]  st;

    int errors = 0;
    int checks = 0;

    acq_seq_ctrl #(.CNT_W(32), .CLR_CYCLES(4)) dut (
        .rx_clk1(clk), .rx_reset(rst), .arm(arm), .abort(abort),
        .cfg_peak_mode(cfg_peak_mode), .cfg_extract_enable(cfg_extract_enable),
        .cfg_div_n(cfg_div_n), .cfg_div_n_maxmin(cfg_div_n_maxmin),
        .cfg_pre_len(cfg_pre_len), .cfg_post_len(cfg_post_len),
        .trig_in(trig_in), .force_trig(force_trig),
        .fifo_all_wen(fifo_all_wen), .fifo_full(fifo_full),
        .count_clr(count_clr), .peak_mode(peak_mode), .extract_enable(extract_enable),
        .div_n(div_n), .div_n_maxmin(div_n_maxmin), .wr_gate(wr_gate),
        .words_written(ww), .trig_pos(trig_pos), .acq_busy(acq_busy),
        .acq_done(acq_done), .overflow(overflow), .state(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit);
        for (int i = 0; i < limit && st !== s; i++) step();
    endtask

    task automatic wait_ww(input logic [31:0] w, input int limit);
        for (int i = 0; i < limit && ww !== w; i++) step();
    endtask

    task automatic do_arm(input logic [31:0] pre, input logic [31:0] post);
        cfg_pre_len  = pre;
        cfg_post_len = post;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(st), 32'd0);
        chk({tag, "_count_clr"}, 32'(count_clr), 32'd1);
        chk({tag, "_words"}, ww, 32'd0);
        chk({tag, "_trig_pos"}, trig_pos, 32'd0);
        chk({tag, "_busy"}, 32'(acq_busy), 32'd0);
        chk({tag, "_done"}, 32'(acq_done), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_wr_gate"}, 32'(wr_gate), 32'd0);
        chk({tag, "_div_n"}, div_n, 32'd0);
        chk({tag, "_div_n_maxmin"}, div_n_maxmin, 32'd0);
        chk({tag, "_peak_mode"}, 32'(peak_mode), 32'd0);
        chk({tag, "_extract"}, 32'(extract_enable), 32'd0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0;
        cfg_peak_mode = 1'b0; cfg_extract_enable = 1'b0;
        cfg_div_n = 32'd0; cfg_div_n_maxmin = 32'd0;
        cfg_pre_len = 32'd0; cfg_post_len = 32'd0;
        trig_in = 1'b0; force_trig = 1'b0; fifo_all_wen = 1'b0; fifo_full = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        rst = 1'b0;

        // Arm: count_clr low for cycles 1-4, PRE at cycle 5, config latched.
        cfg_div_n = 32'h0000_0123; cfg_div_n_maxmin = 32'h0000_0456;
        cfg_peak_mode = 1'b1; cfg_extract_enable = 1'b1;
        do_arm(32'd8, 32'd16);
        chk("arm_state", 32'(st), 32'd1);
        chk("arm_clr_c1", 32'(count_clr), 32'd0);
        chk("arm_busy", 32'(acq_busy), 32'd1);
        chk("arm_peak", 32'(peak_mode), 32'd1);
        chk("arm_extract", 32'(extract_enable), 32'd1);
        cfg_div_n = 32'h0000_0999; cfg_peak_mode = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("clr_low", 32'(count_clr), 32'd0);
        end
        step();
        chk("pre_state_c5", 32'(st), 32'd2);
        chk("pre_clr_high", 32'(count_clr), 32'd1);
        chk("div_n_held", div_n, 32'h0000_0123);
        chk("div_mm_held", div_n_maxmin, 32'h0000_0456);
        chk("peak_held", 32'(peak_mode), 32'd1);

        // pre=8, post=16, trigger after 20 words.
        fifo_all_wen = 1'b1;
        wait_ww(32'd8, 20);
        chk("pre_to_wait", 32'(st), 32'd3);
        wait_ww(32'd19, 30);
        chk("wait_at19", 32'(st), 32'd3);
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
        chk("trig_post", 32'(st), 32'd4);
        chk("trig_pos20", trig_pos, 32'd20);
        wait_state(3'd5, 40);
        chk("done_state", 32'(st), 32'd5);
        chk("done_words36", ww, 32'd36);
        chk("done_flag", 32'(acq_done), 32'd1);
        chk("done_busy", 32'(acq_busy), 32'd0);
        chk("done_ovf", 32'(overflow), 32'd0);
        chk("done_gate", 32'(wr_gate), 32'd0);
        step();
        chk("done_hold_words", ww, 32'd36);

        // pre=0, post=0, force_trig held.
        force_trig = 1'b1;
        do_arm(32'd0, 32'd0);
        chk("z_clear", 32'(st), 32'd1);
        chk("z_words_clr", ww, 32'd0);
        chk("z_trig_clr", trig_pos, 32'd0);
        step(); step(); step();
        step();
        chk("z_wait", 32'(st), 32'd3);
        step();
        chk("z_post", 32'(st), 32'd4);
        chk("z_post_words", ww, 32'd1);
        step();
        chk("z_done", 32'(st), 32'd5);
        chk("z_done_words", ww, 32'd1);
        force_trig = 1'b0;

        // trig_in high through PRE must not trigger until it re-rises.
        trig_in = 1'b1;
        do_arm(32'd4, 32'd2);
        wait_state(3'd3, 20);
        chk("h_wait_words", ww, 32'd4);
        step(); step(); step();
        chk("h_no_trig", 32'(st), 32'd3);
        chk("h_words7", ww, 32'd7);
        trig_in = 1'b0;
        step();
        trig_in = 1'b1;
        step();
        chk("h_post", 32'(st), 32'd4);
        chk("h_trig_pos", trig_pos, 32'd9);
        wait_state(3'd5, 10);
        chk("h_done_words", ww, 32'd11);
        trig_in = 1'b0;

        // Overflow: FIFO full for 3 valid cycles in POST.
        fifo_all_wen = 1'b0;
        do_arm(32'd0, 32'd16);
        wait_state(3'd3, 10);
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        chk("o_post", 32'(st), 32'd4);
        fifo_all_wen = 1'b1; fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("o_gate_full", 32'(wr_gate), 32'd0);
            step();
        end
        chk("o_ovf_set", 32'(overflow), 32'd1);
        chk("o_still_post", 32'(st), 32'd4);
        chk("o_no_count", ww, 32'd0);
        fifo_full = 1'b0;
        wait_state(3'd5, 40);
        chk("o_done", 32'(st), 32'd5);
        chk("o_words16", ww, 32'd16);
        chk("o_ovf_sticky", 32'(overflow), 32'd1);

        // Abort and arm together in WAIT_TRIG.
        do_arm(32'd2, 32'd4);
        chk("a_ovf_clr", 32'(overflow), 32'd0);
        wait_state(3'd3, 20);
        chk("a_wait", 32'(st), 32'd3);
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        chk("a_idle", 32'(st), 32'd0);
        chk("a_busy", 32'(acq_busy), 32'd0);
        chk("a_clr", 32'(count_clr), 32'd1);
        chk("a_done", 32'(acq_done), 32'd0);
        fifo_all_wen = 1'b0;
        step();
        chk("a_stay_idle", 32'(st), 32'd0);
        do_arm(32'd2, 32'd4);
        chk("r_clear", 32'(st), 32'd1);
        chk("r_words_clr", ww, 32'd0);
        chk("r_trig_clr", trig_pos, 32'd0);
        fifo_all_wen = 1'b1;
        wait_state(3'd3, 20);
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        chk("r_post", 32'(st), 32'd4);
        chk("r_trig_pos", trig_pos, 32'd3);

        // Asynchronous reset in POST: values change without a clock edge.
        rst = 1'b1;
        #2;
        chk_reset_vals("arst");
        step();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acq_seq_ctrl.md
Name: acq_seq_ctrl

Overview:
Acquisition sequencer for the ADC receive datapath on rx_clk1. It latches the capture configuration at arm, pulses the active-low count clear into the normal/peak paths, and gates the datapath write strobe through pre-trigger, wait-trigger and post-trigger phases. It reports the trigger position, the written word count, completion and overflow to the host/DDR side.

Parameters:
CNT_W, 32, width of length and position counters
CLR_CYCLES, 4, number of cycles count_clr is held low after arm (>=1)

Ports:
rx_clk1  in  1  acquisition clock; all logic is on its rising edge
rx_reset  in  1  asynchronous, active-high reset
arm  in  1  single-cycle start request
abort  in  1  single-cycle cancel request
cfg_peak_mode  in  1  peak mode select, sampled at arm
cfg_extract_enable  in  1  decimation enable, sampled at arm
cfg_div_n  in  32  normal-path divide ratio, sampled at arm
cfg_div_n_maxmin  in  32  peak-path divide ratio, sampled at arm
cfg_pre_len  in  CNT_W  pre-trigger words
cfg_post_len  in  CNT_W  post-trigger words
trig_in  in  1  trigger level; rising edge is used
force_trig  in  1  level, forces trigger in WAIT_TRIG
fifo_all_wen  in  1  128-bit word valid from the datapath mux
fifo_full  in  1  downstream FIFO full
count_clr  out  1  active-low clear to the datapath
peak_mode  out  1  latched cfg_peak_mode
extract_enable  out  1  latched cfg_extract_enable
div_n  out  32  latched cfg_div_n
div_n_maxmin  out  32  latched cfg_div_n_maxmin
wr_gate  out  1  qualified FIFO write enable
words_written  out  CNT_W  accepted words since arm
trig_pos  out  CNT_W  words_written value at the trigger
acq_busy  out  1  high in CLEAR, PRE, WAIT_TRIG and POST
acq_done  out  1  high in DONE
overflow  out  1  sticky: a word was lost while full
state  out  3  IDLE=0, CLEAR=1, PRE=2, WAIT_TRIG=3, POST=4, DONE=5

Behaviour:
- Reset values: state=IDLE; count_clr=1; peak_mode=0; extract_enable=0; div_n=0; div_n_maxmin=0; words_written=0; trig_pos=0; acq_busy=0; acq_done=0; overflow=0; wr_gate=0; trigger edge register=0.
- All outputs are registered except wr_gate.
- wr_gate = fifo_all_wen & ~fifo_full & (state in PRE, WAIT_TRIG or POST), combinational.
- accept = wr_gate. Each accept increments words_written and the phase counter in the same edge.
- IDLE or DONE, arm=1:
  - latch all cfg_* inputs;
  - clear words_written, trig_pos, overflow and the phase counter;
  - go to CLEAR.
  - Arm in any other state is ignored.
- CLEAR:
  - count_clr=0 for exactly CLR_CYCLES cycles, starting the cycle after arm;
  - then go to PRE, with count_clr=1 again.
- PRE:
  - count accepted words;
  - go to WAIT_TRIG on the edge where the count reaches cfg_pre_len;
  - if cfg_pre_len=0, go to WAIT_TRIG directly after CLEAR.
  - Triggers are ignored in PRE, even in the transition cycle.
- WAIT_TRIG:
  - writes continue to be accepted and counted;
  - trigger = (trig_in & ~trig_in_d) | force_trig;
  - on trigger, trig_pos <= words_written, including any word accepted in that cycle; phase counter clears; go to POST.
  - A trig_in already high on entry to WAIT_TRIG is not a trigger until it falls and rises again.
- POST:
  - count accepted words;
  - go to DONE on the edge where the count reaches cfg_post_len;
  - if cfg_post_len=0, go to DONE on the next cycle with no words accepted in POST.
- DONE: acq_done=1 and words_written is held until the next arm or abort.
- Overflow: fifo_all_wen & fifo_full in PRE, WAIT_TRIG or POST sets overflow. The word is not counted and the state is not affected.
- abort=1 in any state:
  - go to IDLE next edge; count_clr=1; acq_done=0;
  - latched configuration and counters are held.
  - abort and arm in the same cycle: abort wins.
- Counter saturation is not required: lengths must be below 2^CNT_W-1.
- rx_reset mid-capture forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- CLR_CYCLES=4; arm at cycle 0 -> count_clr low during cycles 1-4, state=PRE at cycle 5; cfg_div_n is changed after arm -> div_n stays at the arm-time value.
- pre=8, post=16, fifo_all_wen=1, trig_in rises after 20 words -> trig_pos=20, words_written=36, acq_done=1, overflow=0.
- pre=0, post=0, force_trig held at 1 -> states go CLEAR→WAIT_TRIG→POST→DONE with words_written ≤ 1.
- trig_in held high through PRE -> no trigger until trig_in falls and rises again; trig_pos equals the word count at that second rise.
- fifo_full=1 for 3 valid cycles in POST -> overflow=1, wr_gate=0 on those cycles, post length still reached with 16 accepted words.
- abort and arm together in WAIT_TRIG -> IDLE next cycle, acq_busy=0; a later arm restarts with cleared counters; asserting rx_reset in POST -> all outputs take reset values immediately.
